keyspace_checker: RTL and testbench
===================================

Name: keyspace_checker

Overview:
- Downstream consumer of the 24-bit brute-force key generator; issues its start pulses.
- Each candidate key drives the RC4 decrypt core. This block receives the decrypted plaintext bytes over a valid/ready stream and checks every byte for legal characters.
- On an illegal byte it aborts the decrypt core and requests the next key.
- On a full legal message, or once the keyspace is exhausted, it reports a sticky verdict.

Parameters:
MSG_LEN, 32, decrypted message length in bytes (1..255)
CHAR_LO, 8'h61, lowest legal character ('a')
CHAR_HI, 8'h7A, highest legal character ('z')
ALLOW_SPACE, 1, 1 = byte 8'h20 is also legal

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
key_valid  in  1  key generator "finished": a new candidate key is on key_in (level, sampled in IDLE)
key_last  in  1  key generator "terminated": the current key is the last in range
key_in  in  24  candidate key from key generator
byte_valid  in  1  decrypted byte available
byte_data  in  8  decrypted byte
byte_ready  out  1  checker accepts a byte this cycle
abort  out  1  one-cycle pulse: decrypt core must stop the current key
next_key  out  1  one-cycle pulse to key generator start
cur_key  out  24  key under test
found  out  1  sticky: valid plaintext found
found_key  out  24  key that produced the valid plaintext
exhausted  out  1  sticky: all keys rejected
bad_index  out  8  byte position of the last rejection

Behaviour:
- Reset (async assert, sync release): state = IDLE; all outputs 0; internal count = 0; last flag = 0.
- Legal byte: CHAR_LO <= b <= CHAR_HI, or (ALLOW_SPACE && b == 8'h20). Unsigned 8-bit compare.
- States: IDLE, CHECK, REJECT, REQ_NEXT, FOUND, EXHAUSTED.
- IDLE:
  - byte_ready = 0.
  - If key_valid: latch key_in -> cur_key, latch key_last -> last flag, count = 0, go to CHECK next cycle.
- CHECK:
  - byte_ready = 1, combinationally, for the whole state.
  - A transfer occurs when byte_valid && byte_ready.
  - Legal byte with count == MSG_LEN-1 -> FOUND.
  - Legal byte otherwise -> count + 1, stay in CHECK.
  - Illegal byte -> bad_index = count; abort = 1 in the following cycle; go to REJECT.
  - No byte_valid -> hold; no timeout.
- REJECT (1 cycle):
  - abort = 1; byte_ready = 0.
  - last flag = 1 -> EXHAUSTED; else -> REQ_NEXT.
- REQ_NEXT (1 cycle): next_key = 1; then IDLE.
- FOUND:
  - found = 1; found_key = cur_key; byte_ready = 0.
  - Terminal until reset. No further next_key.
- EXHAUSTED: exhausted = 1, terminal until reset.
- Bootstrap: the first key needs an external start to the key generator. After that, the block paces the search by itself: key_valid arrives 2-3 cycles after next_key.
- Latency: accept to FOUND is 1 cycle after the last byte. Illegal byte to next_key is 2 cycles.
- found and exhausted are never both 1.
- Boundary rules:
  - key_valid outside IDLE is ignored.
  - Bytes presented outside CHECK are not accepted (byte_ready = 0).
  - MSG_LEN = 1 goes to FOUND on the first legal byte.
  - An illegal final byte (index MSG_LEN-1) rejects.
  - A legal message on the last key gives FOUND, not EXHAUSTED.
  - reset_n asserted mid-CHECK clears everything immediately; abort is not pulsed.
- count width is 8 bits; it never wraps (MSG_LEN <= 255).

Test Plan:
1. Reset, key_valid=1 with key_in=24'h000000, stream 32 bytes of 8'h61 -> FOUND; found=1, found_key=0, next_key never pulsed, byte_ready low after the last byte.
2. key 24'h000005, bytes "ab", then 8'h41 at index 2 -> bad_index=2; abort high 1 cycle; next_key high exactly 1 cycle, 1 cycle later; back in IDLE.
3. key_valid with key_last=1 and byte 8'hFF at index 0 -> abort, no next_key, exhausted=1 stays high across 100 idle cycles.
4. Boundary bytes 8'h60, 8'h7B, 8'h20 with ALLOW_SPACE=0 -> each rejected. 8'h61, 8'h7A, and 8'h20 with ALLOW_SPACE=1 -> each accepted.
5. Gaps in byte_valid (random stalls) plus key_valid pulses during CHECK -> count unaffected, cur_key unchanged, FOUND after 32 legal bytes.
6. Drop reset_n at byte 10 of CHECK -> all outputs 0 asynchronously. A fresh key_valid then restarts checking at count 0.

Source files
------------

// File: rtl/keyspace_checker.sv
// keyspace_checker
//
// Sits between the 24-bit brute-force key generator and the RC4 decrypt core.
// For each candidate key it checks the decrypted plaintext stream one byte at
// a time. The first illegal byte aborts the decrypt core and asks the key
// generator for the next key. A fully legal message or an exhausted key range
// produces a sticky verdict.
//
// Ports:
//   clk, reset_n            clock (rising edge), async active-low reset
//   key_valid/key_last/key_in   candidate key from the generator (sampled in IDLE)
//   byte_valid/byte_data    decrypted byte stream in
//   byte_ready              byte accepted this cycle (high only while checking)
//   abort                   one-cycle pulse: stop decrypting the current key
//   next_key                one-cycle pulse: start the key generator
//   cur_key                 key under test
//   found/found_key         sticky success verdict and the winning key
//   exhausted               sticky: every key in range was rejected
//   bad_index               byte position of the most recent rejection
module keyspace_checker #(
    parameter int unsigned MSG_LEN     = 32,
    parameter logic [7:0]  CHAR_LO     = 8'h61,
    parameter logic [7:0]  CHAR_HI     = 8'h7A,
    parameter bit          ALLOW_SPACE = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        key_valid,
    input  logic        key_last,
    input  logic [23:0] key_in,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        abort,
    output logic        next_key,
    output logic [23:0] cur_key,
    output logic        found,
    output logic [23:0] found_key,
    output logic        exhausted,
    output logic [7:0]  bad_index
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_CHECK     = 3'd1;
    localparam logic [2:0] S_REJECT    = 3'd2;
    localparam logic [2:0] S_REQ_NEXT  = 3'd3;
    localparam logic [2:0] S_FOUND     = 3'd4;
    localparam logic [2:0] S_EXHAUSTED = 3'd5;

    // Index of the final byte of a message; count never goes beyond it.
    localparam logic [7:0] LAST_IDX = 8'(MSG_LEN - 1);

    logic [2:0]  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic        last_q, last_d;
    logic [23:0] cur_key_q, cur_key_d;
    logic [23:0] found_key_q, found_key_d;
    logic [7:0]  bad_index_q, bad_index_d;

    logic byte_legal;
    logic xfer;

    assign byte_legal = ((byte_data >= CHAR_LO) && (byte_data <= CHAR_HI)) ||
                        (ALLOW_SPACE && (byte_data == 8'h20));

    // Control outputs are pure state decodes, so an asynchronous reset
    // clears them immediately and a reset mid-check never pulses abort.
    assign byte_ready = (state_q == S_CHECK);
    assign abort      = (state_q == S_REJECT);
    assign next_key   = (state_q == S_REQ_NEXT);
    assign found      = (state_q == S_FOUND);
    assign exhausted  = (state_q == S_EXHAUSTED);
    assign cur_key    = cur_key_q;
    assign found_key  = found_key_q;
    assign bad_index  = bad_index_q;

    assign xfer = byte_valid && byte_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        last_d      = last_q;
        cur_key_d   = cur_key_q;
        found_key_d = found_key_q;
        bad_index_d = bad_index_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid) begin
                    cur_key_d = key_in;
                    last_d    = key_last;
                    count_d   = 8'd0;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (xfer) begin
                    if (!byte_legal) begin
                        bad_index_d = count_q;
                        state_d     = S_REJECT;
                    end else if (count_q == LAST_IDX) begin
                        found_key_d = cur_key_q;
                        state_d     = S_FOUND;
                    end else begin
                        count_d = count_q + 8'd1;
                    end
                end
            end
            // The last key of the range is not followed by a start pulse:
            // there is nothing left to generate.
            S_REJECT:   state_d = last_q ? S_EXHAUSTED : S_REQ_NEXT;
            S_REQ_NEXT: state_d = S_IDLE;
            S_FOUND, S_EXHAUSTED: begin
                state_d = state_q;
            end
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            count_q     <= 8'd0;
            last_q      <= 1'b0;
            cur_key_q   <= 24'd0;
            found_key_q <= 24'd0;
            bad_index_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            last_q      <= last_d;
            cur_key_q   <= cur_key_d;
            found_key_q <= found_key_d;
            bad_index_q <= bad_index_d;
        end
    end

endmodule

// File: tb/tb_keyspace_checker.sv
module tb_keyspace_checker;

    localparam int MSG_LEN = 32;

    localparam logic [1:0] EV_ABORT = 2'd0;
    localparam logic [1:0] EV_NEXT  = 2'd1;
    localparam logic [1:0] EV_FOUND = 2'd2;
    localparam logic [1:0] EV_EXH   = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [23:0] key;
        logic [7:0]  idx;
        int          cyc;
    } ev_t;

    // main instance (defaults: MSG_LEN=32, ALLOW_SPACE=1)
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        key_valid = 1'b0, key_last = 1'b0;
    logic [23:0] key_in = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, abort, next_key, found, exhausted;
    logic [23:0] cur_key, found_key;
    logic [7:0]  bad_index;

    // second instance: single-byte messages, space not allowed
    logic        s_rst_n = 1'b0;
    logic        s_kv = 1'b0, s_last = 1'b0;
    logic [23:0] s_key = '0;
    logic        s_bv = 1'b0;
    logic [7:0]  s_bd = '0;
    logic        s_ready, s_abort, s_next, s_found, s_exh;
    logic [23:0] s_cur, s_fkey;
    logic [7:0]  s_bidx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stall_pct = 0;
    bit noise = 1'b0;
    ev_t expq[$];
    logic [7:0] msg [MSG_LEN];
    bit found_p = 1'b0, exh_p = 1'b0;

    keyspace_checker dut (
        .clk(clk), .reset_n(reset_n),
        .key_valid(key_valid), .key_last(key_last), .key_in(key_in),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .abort(abort), .next_key(next_key), .cur_key(cur_key),
        .found(found), .found_key(found_key), .exhausted(exhausted),
        .bad_index(bad_index)
    );

    keyspace_checker #(.MSG_LEN(1), .ALLOW_SPACE(1'b0)) dut_s (
        .clk(clk), .reset_n(s_rst_n),
        .key_valid(s_kv), .key_last(s_last), .key_in(s_key),
        .byte_valid(s_bv), .byte_data(s_bd), .byte_ready(s_ready),
        .abort(s_abort), .next_key(s_next), .cur_key(s_cur),
        .found(s_found), .found_key(s_fkey), .exhausted(s_exh),
        .bad_index(s_bidx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference rule for a legal plaintext character.
    function automatic bit legal(input logic [7:0] b, input bit sp);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (sp && (b == 8'h20));
    endfunction

    function automatic logic [7:0] rand_legal();
        case ($urandom_range(0, 9))
            0:       return 8'h61;
            1:       return 8'h7A;
            2:       return 8'h20;
            default: return 8'(8'h61 + $urandom_range(0, 25));
        endcase
    endfunction

    function automatic logic [7:0] rand_illegal();
        case ($urandom_range(0, 8))
            0:       return 8'h60;
            1:       return 8'h7B;
            2:       return 8'h1F;
            3:       return 8'h21;
            4:       return 8'h41;
            5:       return 8'h5B;
            6:       return 8'hFF;
            7:       return 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    task automatic fill_msg(input int bad);
        for (int i = 0; i < MSG_LEN; i++) msg[i] = rand_legal();
        if (bad >= 0) msg[bad] = rand_illegal();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [1:0] kind, input logic [23:0] key, input logic [7:0] idx);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event actual kind=%0d key=%h idx=%0d cyc=%0d required none",
                     kind, key, idx, cyc);
            return;
        end
        e = expq.pop_front();
        if (e.kind !== kind || e.key !== key || e.idx !== idx || e.cyc != cyc) begin
            failures++;
            $display("FAIL event actual kind=%0d key=%h idx=%0d cyc=%0d required kind=%0d key=%h idx=%0d cyc=%0d",
                     kind, key, idx, cyc, e.kind, e.key, e.idx, e.cyc);
        end
    endtask

    // Monitor: compares every verdict/pulse the DUT shows against the queue.
    always @(negedge clk) begin
        if (abort)                 observe(EV_ABORT, cur_key, bad_index);
        if (next_key)              observe(EV_NEXT, cur_key, 8'd0);
        if (found && !found_p)     observe(EV_FOUND, found_key, 8'd0);
        if (exhausted && !exh_p)   observe(EV_EXH, cur_key, 8'd0);
        found_p = found;
        exh_p   = exhausted;
        checks++;
        if (found && exhausted) begin
            failures++;
            $display("FAIL verdict_exclusive actual found=1 exhausted=1 required not both");
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        key_valid = 1'b0; key_last = 1'b0; key_in = '0;
        byte_valid = 1'b0; byte_data = '0;
        expq.delete();
        @(negedge clk);
        chk("reset_outputs", {byte_ready, abort, next_key, found, exhausted,
                              cur_key, found_key, bad_index}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Issue one key and stream up to n_send bytes of msg[]. Must be called
    // at a negedge with the DUT idle. Expected events are queued just
    // before the edge that accepts the terminating byte.
    task automatic run_key(input logic [23:0] key, input bit last, input int n_send, output bit ok);
        int  bad, c, tries;
        bit  v, rdy, term, stop;
        bad = -1;
        for (int i = 0; i < MSG_LEN; i++)
            if (bad < 0 && !legal(msg[i], 1'b1)) bad = i;
        key_valid = 1'b1; key_in = key; key_last = last;
        @(negedge clk);
        key_valid = 1'b0; key_in = 24'($urandom); key_last = 1'($urandom);
        ok = 1'b1;
        stop = 1'b0;
        for (int i = 0; i < n_send && ok && !stop; i++) begin
            term = (i == bad) || (bad < 0 && i == MSG_LEN - 1);
            tries = 0;
            forever begin
                v = ($urandom_range(0, 99) >= stall_pct);
                byte_valid = v;
                byte_data  = v ? msg[i] : 8'($urandom);
                if (noise) begin
                    key_valid = ($urandom_range(0, 3) == 0);
                    key_in    = 24'($urandom);
                    key_last  = 1'($urandom);
                end
                rdy = byte_ready;
                c   = cyc;
                if (v && rdy && term) begin
                    if (i == bad) begin
                        expq.push_back('{EV_ABORT, key, 8'(i), c + 1});
                        expq.push_back('{last ? EV_EXH : EV_NEXT, key, 8'd0, c + 2});
                    end else begin
                        expq.push_back('{EV_FOUND, key, 8'd0, c + 1});
                    end
                end
                @(negedge clk);
                if (v && rdy) break;
                tries++;
                if (tries > 200) begin
                    checks++; failures++;
                    $display("FAIL byte_accept_timeout actual=no_ready required=ready key=%h idx=%0d", key, i);
                    ok = 1'b0;
                    break;
                end
            end
            if (i == bad) stop = 1'b1;
        end
        byte_valid = 1'b0; key_valid = 1'b0; key_last = 1'b0;
        // Next key arrives 2-3 cycles after the abort-side exit point.
        if (ok && stop && !last) repeat ($urandom_range(2, 3)) @(negedge clk);
    endtask

    task automatic check_found(input logic [23:0] key);
        int rdy_cnt;
        repeat (3) @(negedge clk);
        chk("queue_drained_found", 64'(expq.size()), 64'd0);
        rdy_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            byte_valid = 1'b1; byte_data = 8'h61;
            key_valid = 1'b1; key_in = 24'($urandom);
            @(negedge clk);
            if (byte_ready) rdy_cnt++;
        end
        byte_valid = 1'b0; key_valid = 1'b0;
        chk("ready_after_found", 64'(rdy_cnt), 64'd0);
        chk("found_sticky", {found, exhausted}, 64'b10);
        chk("found_key", found_key, key);
    endtask

    task automatic check_exh(input int n);
        int rdy_cnt;
        repeat (3) @(negedge clk);
        chk("queue_drained_exh", 64'(expq.size()), 64'd0);
        rdy_cnt = 0;
        for (int i = 0; i < n; i++) begin
            byte_valid = 1'($urandom); byte_data = 8'h61;
            key_valid = 1'($urandom); key_in = 24'($urandom); key_last = 1'($urandom);
            @(negedge clk);
            if (byte_ready) rdy_cnt++;
        end
        byte_valid = 1'b0; key_valid = 1'b0; key_last = 1'b0;
        chk("ready_after_exh", 64'(rdy_cnt), 64'd0);
        chk("exh_sticky", {found, exhausted}, 64'b01);
    endtask

    task automatic space_case(input logic [7:0] b);
        bit exp_ok;
        logic [23:0] k;
        exp_ok = legal(b, 1'b0);
        k = {16'h0100, b};
        @(negedge clk); s_rst_n = 1'b0; s_kv = 1'b0; s_bv = 1'b0;
        @(negedge clk); s_rst_n = 1'b1;
        @(negedge clk); s_kv = 1'b1; s_key = k; s_last = 1'b1;
        @(negedge clk); s_kv = 1'b0;
        chk("s_ready", s_ready, 1'b1);
        s_bv = 1'b1; s_bd = b;
        @(negedge clk); s_bv = 1'b0;
        chk("s_found", s_found, exp_ok);
        chk("s_abort", s_abort, !exp_ok);
        @(negedge clk);
        chk("s_exhausted", s_exh, !exp_ok);
        chk("s_found_key", s_fkey, exp_ok ? k : 24'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int nkeys, bad;
        bit fin_legal, last;
        logic [23:0] k;

        // 1: single key, all 'a' -> found, no next_key
        do_reset();
        for (int i = 0; i < MSG_LEN; i++) msg[i] = 8'h61;
        run_key(24'h000000, 1'b0, MSG_LEN, ok);
        check_found(24'h000000);

        // 2: "ab" then 'A' at index 2
        do_reset();
        fill_msg(-1);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h41;
        run_key(24'h000005, 1'b0, MSG_LEN, ok);
        chk("bad_index_idx2", bad_index, 8'd2);

        // 3: last key, 0xFF at index 0 -> exhausted, sticky
        fill_msg(-1);
        msg[0] = 8'hFF;
        run_key(24'hABCDEF, 1'b1, MSG_LEN, ok);
        check_exh(100);

        // 4: boundary characters, space allowed on main instance
        do_reset();
        for (int i = 0; i < MSG_LEN; i++)
            msg[i] = (i % 3 == 0) ? 8'h20 : ((i % 3 == 1) ? 8'h7A : 8'h61);
        run_key(24'h123456, 1'b1, MSG_LEN, ok);
        check_found(24'h123456);
        space_case(8'h60);
        space_case(8'h7B);
        space_case(8'h20);
        space_case(8'h1F);
        space_case(8'h61);
        space_case(8'h7A);

        // 5: random episodes with stalls and spurious key_valid
        stall_pct = 30;
        noise = 1'b1;
        for (int ep = 0; ep < 8; ep++) begin
            do_reset();
            nkeys = $urandom_range(1, 5);
            fin_legal = (ep % 2 == 0);
            ok = 1'b1;
            k = '0;
            for (int j = 0; j < nkeys && ok; j++) begin
                k = 24'($urandom);
                if (j == nkeys - 1) begin
                    last = fin_legal ? 1'($urandom) : 1'b1;
                    bad  = fin_legal ? -1 : $urandom_range(0, MSG_LEN - 1);
                end else begin
                    last = 1'b0;
                    bad  = $urandom_range(0, MSG_LEN - 1);
                end
                if (ep == 1 && j == nkeys - 1) bad = MSG_LEN - 1;
                fill_msg(bad);
                run_key(k, last, MSG_LEN, ok);
            end
            if (fin_legal) check_found(k);
            else           check_exh(20);
        end

        // 6: async reset mid-check, then a fresh key restarts at count 0
        stall_pct = 0;
        noise = 1'b0;
        do_reset();
        fill_msg(-1);
        run_key(24'h5A5A5A, 1'b0, 10, ok);
        #2 reset_n = 1'b0;
        #1 chk("async_reset_outputs", {byte_ready, abort, next_key, found, exhausted,
                                       cur_key, found_key, bad_index}, 64'd0);
        @(negedge clk);
        chk("held_reset_outputs", {byte_ready, abort, next_key, found, exhausted,
                                   cur_key, found_key, bad_index}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        fill_msg(-1);
        run_key(24'h0F0F0F, 1'b0, MSG_LEN, ok);
        check_found(24'h0F0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
